// File: rtl/picosoc_membus_pkg.sv
// Shared types and constants for the picosoc memory-bus router.
// Optional stalled-target timeout is enabled by defining PICOSOC_MEMBUS_TIMEOUT_EN.
package picosoc_membus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int SEL_W = 5;
   typedef logic [SEL_W-1:0] sel_t;

   localparam sel_t SEL_RAM      = 5'd0;
   localparam sel_t SEL_FLASH    = 5'd1;
   localparam sel_t SEL_UNMAPPED = 5'd2;
   localparam sel_t SEL_IO_BASE  = 5'd3;

   localparam logic [7:0] REGION_RAM     = 8'h00;
   localparam logic [7:0] REGION_FLASH   = 8'h01;
   localparam logic [7:0] REGION_IO_BASE = 8'h02;

   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hFFFF_FFFF;

   function automatic sel_t decode_region(input logic [7:0] region, input int num_io);
      logic [7:0] io_idx;
      io_idx = region - REGION_IO_BASE;
      if (region == REGION_RAM)
         return SEL_RAM;
      else if (region == REGION_FLASH)
         return SEL_FLASH;
      else if (region >= REGION_IO_BASE && int'(io_idx) < num_io)
         return SEL_IO_BASE + sel_t'(io_idx);
      else
         return SEL_UNMAPPED;
   endfunction

endpackage

// File: rtl/picosoc_membus_sram.sv
// Single-port byte-writable SRAM with registered read; a read in a write cycle returns old data.
module picosoc_sram_bw #(
   parameter int MEM_WORDS = 256
) (
   input  logic                         clk_i,
   input  logic                         en_i,
   input  logic [3:0]                   we_i,
   input  logic [$clog2(MEM_WORDS)-1:0] addr_i,
   input  logic [31:0]                  wdata_i,
   output logic [31:0]                  rdata_o
);

   logic [31:0] mem_q [MEM_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i)
         rdata_q <= mem_q[addr_i];
      for (int b = 0; b < 4; b++)
         if (we_i[b])
            mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/picosoc_membus.sv
// Routes the picorv32 native memory bus to SRAM, SPI flash, NUM_IO iomem channels or an error responder.
// Define PICOSOC_MEMBUS_TIMEOUT_EN to build the stalled-target timeout.
module picosoc_membus
   import picosoc_membus_pkg::*;
#(
   parameter int          MEM_WORDS      = 256,
   parameter int          NUM_IO         = 4,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wstrb,
   output logic [31:0]           mem_rdata,
   output logic                  spimem_valid,
   input  logic                  spimem_ready,
   output logic [23:0]           spimem_addr,
   input  logic [31:0]           spimem_rdata,
   output logic [NUM_IO-1:0]     iomem_valid,
   input  logic [NUM_IO-1:0]     iomem_ready,
   output logic [3:0]            iomem_wstrb,
   output logic [31:0]           iomem_addr,
   output logic [31:0]           iomem_wdata,
   input  logic [32*NUM_IO-1:0]  iomem_rdata,
   output logic                  bus_err,
   output logic [31:0]           bus_err_addr,
   input  logic                  bus_err_clr
);

   localparam int AW = $clog2(MEM_WORDS);

   // Handshake: the CPU holds mem_valid and the request fields until it sees the one-cycle
   // mem_ready pulse; a target valid stays high until the cycle its ready is sampled.
   state_t            state_q, state_d;
   sel_t              sel_q, sel_d;
   logic              mem_ready_q, mem_ready_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              spimem_valid_q, spimem_valid_d;
   logic [NUM_IO-1:0] iomem_valid_q, iomem_valid_d;
   logic              bus_err_q, bus_err_d;
   logic [31:0]       bus_err_addr_q, bus_err_addr_d;

   logic        tgt_ready, timeout, done, err_event, accept;
   logic [31:0] tgt_rdata, sram_rdata;
   logic [3:0]  sram_we;

   assign accept = (state_q == ST_IDLE) && mem_valid;

   always_comb begin
      tgt_ready = 1'b0;
      tgt_rdata = ERR_RDATA;
      if (sel_q == SEL_RAM) begin
         tgt_ready = 1'b1;
         tgt_rdata = sram_rdata;
      end else if (sel_q == SEL_FLASH) begin
         tgt_ready = spimem_ready;
         tgt_rdata = spimem_rdata;
      end else if (sel_q == SEL_UNMAPPED) begin
         tgt_ready = 1'b1;
      end else begin
         for (int k = 0; k < NUM_IO; k++)
            if (sel_q == SEL_IO_BASE + sel_t'(k)) begin
               tgt_ready = iomem_ready[k];
               tgt_rdata = iomem_rdata[32*k +: 32];
            end
      end
   end

`ifdef PICOSOC_MEMBUS_TIMEOUT_EN
   logic [15:0] tmo_cnt_q, tmo_cnt_d;

   // Held at zero outside ACCESS, so it is zero on entry and counts ACCESS cycles.
   assign tmo_cnt_d = (state_q == ST_ACCESS) ? tmo_cnt_q + 16'd1 : 16'd0;
   assign timeout   = (state_q == ST_ACCESS) && !tgt_ready &&
                      (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) tmo_cnt_q <= 16'd0;
      else         tmo_cnt_q <= tmo_cnt_d;
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   assign done      = (state_q == ST_ACCESS) && (tgt_ready || timeout);
   assign err_event = (state_q == ST_ACCESS) && ((tgt_ready && sel_q == SEL_UNMAPPED) || timeout);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (mem_valid) state_d = ST_ACCESS;
         ST_ACCESS: if (done)      state_d = ST_RESP;
         ST_RESP:                  state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sel_d          = accept ? decode_region(mem_addr[31:24], NUM_IO) : sel_q;
      mem_ready_d    = done;
      mem_rdata_d    = mem_rdata_q;
      if (done) mem_rdata_d = timeout ? ERR_RDATA : tgt_rdata;
      spimem_valid_d = spimem_valid_q;
      iomem_valid_d  = iomem_valid_q;
      if (accept) begin
         spimem_valid_d = (sel_d == SEL_FLASH);
         for (int k = 0; k < NUM_IO; k++)
            iomem_valid_d[k] = (sel_d == SEL_IO_BASE + sel_t'(k));
      end else if (done) begin
         spimem_valid_d = 1'b0;
         iomem_valid_d  = '0;
      end
      // A new error beats a same-cycle clear; only the first error address is kept.
      bus_err_d      = err_event ? 1'b1 : (bus_err_clr ? 1'b0 : bus_err_q);
      bus_err_addr_d = (err_event && !bus_err_q) ? mem_addr : bus_err_addr_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sel_q          <= SEL_RAM;
         mem_ready_q    <= 1'b0;
         mem_rdata_q    <= 32'd0;
         spimem_valid_q <= 1'b0;
         iomem_valid_q  <= '0;
         bus_err_q      <= 1'b0;
         bus_err_addr_q <= 32'd0;
      end else begin
         sel_q          <= sel_d;
         mem_ready_q    <= mem_ready_d;
         mem_rdata_q    <= mem_rdata_d;
         spimem_valid_q <= spimem_valid_d;
         iomem_valid_q  <= iomem_valid_d;
         bus_err_q      <= bus_err_d;
         bus_err_addr_q <= bus_err_addr_d;
      end
   end

   // SRAM read is launched at acceptance so its data is ready in the first ACCESS cycle.
   assign sram_we = (state_q == ST_ACCESS && sel_q == SEL_RAM) ? mem_wstrb : 4'd0;

   picosoc_sram_bw #(.MEM_WORDS(MEM_WORDS)) u_sram (
      .clk_i   (clk),
      .en_i    (accept),
      .we_i    (sram_we),
      .addr_i  (mem_addr[AW+1:2]),
      .wdata_i (mem_wdata),
      .rdata_o (sram_rdata)
   );

   assign mem_ready    = mem_ready_q;
   assign mem_rdata    = mem_rdata_q;
   assign spimem_valid = spimem_valid_q;
   assign spimem_addr  = mem_addr[23:0];
   assign iomem_valid  = iomem_valid_q;
   assign iomem_wstrb  = mem_wstrb;
   assign iomem_addr   = mem_addr;
   assign iomem_wdata  = mem_wdata;
   assign bus_err      = bus_err_q;
   assign bus_err_addr = bus_err_addr_q;

endmodule

// File: tb/tb_picosoc_membus.sv
// Self-checking bench for picosoc_membus: CPU driver with target responder and an expected-rdata queue.
module tb_picosoc_membus;

   logic         clk, resetn;
   logic         mem_valid, mem_ready;
   logic [31:0]  mem_addr, mem_wdata, mem_rdata;
   logic [3:0]   mem_wstrb;
   logic         spimem_valid, spimem_ready;
   logic [23:0]  spimem_addr;
   logic [31:0]  spimem_rdata;
   logic [3:0]   iomem_valid, iomem_ready, iomem_wstrb;
   logic [31:0]  iomem_addr, iomem_wdata;
   logic [127:0] iomem_rdata;
   logic         bus_err, bus_err_clr;
   logic [31:0]  bus_err_addr;

   int          n_cmp, n_fail;
   logic [31:0] exp_q[$];

   picosoc_membus #(.MEM_WORDS(256), .NUM_IO(4), .TIMEOUT_CYCLES(8), .ERR_RDATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .resetn(resetn),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
      .spimem_valid(spimem_valid), .spimem_ready(spimem_ready), .spimem_addr(spimem_addr),
      .spimem_rdata(spimem_rdata),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
      .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .bus_err(bus_err), .bus_err_addr(bus_err_addr), .bus_err_clr(bus_err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issues one request from posedge+1 in IDLE; answers the selected target after `delay`
   // ACCESS cycles (negative = never). Returns at posedge+1 in IDLE after the response.
   task automatic cpu_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int delay, input logic [31:0] tdata,
                          output logic [31:0] rdata, output int lat, output logic got,
                          output logic pulse_ok, output logic seen_spi, output logic [3:0] seen_io,
                          output logic [23:0] saddr);
      int wait_cnt;
      rdata = 'x; lat = 1; got = 1'b0; pulse_ok = 1'b0; seen_spi = 1'b0; seen_io = 4'd0;
      saddr = 24'd0; wait_cnt = 0;
      for (int k = 0; k < 4; k++) iomem_rdata[32*k +: 32] = 32'hBAD0_0000 | k;
      mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb; mem_valid = 1'b1;
      for (int c = 0; c < 200 && !got; c++) begin
         @(posedge clk); #1;
         lat++;
         if (mem_ready) begin
            got = 1'b1;
            rdata = mem_rdata;
            mem_valid = 1'b0; spimem_ready = 1'b0; iomem_ready = 4'd0;
         end else if (spimem_valid || (|iomem_valid)) begin
            seen_spi = seen_spi | spimem_valid;
            seen_io  = seen_io | iomem_valid;
            saddr    = spimem_addr;
            if (wait_cnt == delay) begin
               spimem_ready = spimem_valid;
               spimem_rdata = tdata;
               iomem_ready  = iomem_valid;
               for (int k = 0; k < 4; k++) if (iomem_valid[k]) iomem_rdata[32*k +: 32] = tdata;
            end
            wait_cnt++;
         end
      end
      mem_valid = 1'b0; spimem_ready = 1'b0; iomem_ready = 4'd0;
      if (got) begin
         @(posedge clk); #1;
         pulse_ok = !mem_ready;
      end
   endtask

   task automatic test_reset();
      n_cmp += 6;
      if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
      if (mem_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); end
      if (spimem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_spimem_valid got %b want 0", spimem_valid); end
      if (iomem_valid !== 4'd0) begin n_fail++; $display("FAIL reset_iomem_valid got %b want 0", iomem_valid); end
      if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
      if (bus_err_addr !== 32'd0) begin n_fail++; $display("FAIL reset_bus_err_addr got %h want 0", bus_err_addr); end
   endtask

   task automatic test_ram();
      logic [31:0] rd, exp; int lat; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      cpu_req(32'h0000_0010, 32'h1234_5678, 4'hF, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      n_cmp += 2;
      if (!got || lat != 3) begin n_fail++; $display("FAIL ram_wr_latency got %0d want 3", lat); end
      if (!pok) begin n_fail++; $display("FAIL ram_wr_pulse got long want one-cycle"); end
      exp_q.push_back(32'h1234_5678);
      cpu_req(32'h0000_0010, 32'hAAAA_AAAA, 4'b0010, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL ram_prewrite_rdata got %h want %h", rd, exp); end
      exp_q.push_back(32'h1234_AA78);
      cpu_req(32'h0000_0010, 32'd0, 4'h0, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 3;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL ram_read got %h want %h", rd, exp); end
      if (lat != 3) begin n_fail++; $display("FAIL ram_rd_latency got %0d want 3", lat); end
      if (ss || si != 4'd0) begin n_fail++; $display("FAIL ram_no_tgt_valid got spi=%b io=%b want 0", ss, si); end
   endtask

   task automatic test_flash();
      logic [31:0] rd, exp; int lat; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      exp_q.push_back(32'hCAFE_F00D);
      cpu_req(32'h0100_0040, 32'd0, 4'h0, 5, 32'hCAFE_F00D, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 5;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL flash_rdata got %h want %h", rd, exp); end
      if (sa !== 24'h00_0040) begin n_fail++; $display("FAIL flash_addr got %h want 000040", sa); end
      if (!ss) begin n_fail++; $display("FAIL flash_valid got 0 want 1"); end
      if (si !== 4'd0) begin n_fail++; $display("FAIL flash_iomem_quiet got %b want 0000", si); end
      if (lat != 8) begin n_fail++; $display("FAIL flash_latency got %0d want 8", lat); end
   endtask

   task automatic test_io();
      logic [31:0] rd, exp; int lat; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      exp_q.push_back(32'h0000_0042);
      cpu_req(32'h0300_0000, 32'd0, 4'h0, 2, 32'h0000_0042, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 4;
      if (si !== 4'b0010) begin n_fail++; $display("FAIL io1_onehot got %b want 0010", si); end
      if (ss) begin n_fail++; $display("FAIL io1_spi_quiet got 1 want 0"); end
      if (!got || rd !== exp) begin n_fail++; $display("FAIL io1_rdata got %h want %h", rd, exp); end
      if (lat != 5) begin n_fail++; $display("FAIL io1_latency got %0d want 5", lat); end
      exp_q.push_back(32'h5555_0003);
      cpu_req(32'h0500_0010, 32'h0, 4'h0, 0, 32'h5555_0003, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 3;
      if (si !== 4'b1000) begin n_fail++; $display("FAIL io3_onehot got %b want 1000", si); end
      if (!got || rd !== exp) begin n_fail++; $display("FAIL io3_rdata got %h want %h", rd, exp); end
      if (bus_err !== 1'b0) begin n_fail++; $display("FAIL io_no_err got %b want 0", bus_err); end
   endtask

   task automatic test_unmapped();
      logic [31:0] rd, exp; int lat; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      exp_q.push_back(32'hFFFF_FFFF);
      cpu_req(32'h2000_0000, 32'd0, 4'h0, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 5;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL unmapped_rdata got %h want %h", rd, exp); end
      if (lat != 3) begin n_fail++; $display("FAIL unmapped_latency got %0d want 3", lat); end
      if (bus_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_err got %b want 1", bus_err); end
      if (bus_err_addr !== 32'h2000_0000) begin n_fail++; $display("FAIL unmapped_err_addr got %h want 20000000", bus_err_addr); end
      if (ss || si != 4'd0) begin n_fail++; $display("FAIL unmapped_tgt_quiet got spi=%b io=%b want 0", ss, si); end
      cpu_req(32'h3000_0000, 32'd0, 4'h0, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      n_cmp++;
      if (bus_err_addr !== 32'h2000_0000) begin n_fail++; $display("FAIL err_addr_sticky got %h want 20000000", bus_err_addr); end
      bus_err_clr = 1'b1; @(posedge clk); #1; bus_err_clr = 1'b0;
      n_cmp++;
      if (bus_err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", bus_err); end
      cpu_req(32'h0600_0000, 32'd0, 4'h0, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      n_cmp += 2;
      if (bus_err !== 1'b1 || si !== 4'd0) begin n_fail++; $display("FAIL past_io_unmapped got err=%b io=%b want 1/0000", bus_err, si); end
      if (bus_err_addr !== 32'h0600_0000) begin n_fail++; $display("FAIL err_addr_reload got %h want 06000000", bus_err_addr); end
      bus_err_clr = 1'b1; @(posedge clk); #1; bus_err_clr = 1'b0;
   endtask

`ifdef PICOSOC_MEMBUS_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] rd, exp; int lat; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      exp_q.push_back(32'hFFFF_FFFF);
      cpu_req(32'h0200_0000, 32'd0, 4'h0, -1, 32'd0, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 4;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL tmo_rdata got %h want %h", rd, exp); end
      if (lat != 10) begin n_fail++; $display("FAIL tmo_latency got %0d want 10", lat); end
      if (bus_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", bus_err); end
      if (bus_err_addr !== 32'h0200_0000) begin n_fail++; $display("FAIL tmo_err_addr got %h want 02000000", bus_err_addr); end
      bus_err_clr = 1'b1; @(posedge clk); #1; bus_err_clr = 1'b0;
      exp_q.push_back(32'h1357_9BDF);
      cpu_req(32'h0200_0000, 32'd0, 4'h0, 7, 32'h1357_9BDF, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 3;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL tmo_edge_rdata got %h want %h", rd, exp); end
      if (lat != 10) begin n_fail++; $display("FAIL tmo_edge_latency got %0d want 10", lat); end
      if (bus_err !== 1'b0) begin n_fail++; $display("FAIL tmo_edge_err got %b want 0", bus_err); end
   endtask
`else
   task automatic test_long_stall();
      logic [31:0] rd, exp; int lat; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      exp_q.push_back(32'h1357_9BDF);
      cpu_req(32'h0200_0000, 32'd0, 4'h0, 12, 32'h1357_9BDF, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp += 3;
      if (!got || rd !== exp) begin n_fail++; $display("FAIL stall_rdata got %h want %h", rd, exp); end
      if (lat != 15) begin n_fail++; $display("FAIL stall_latency got %0d want 15", lat); end
      if (bus_err !== 1'b0) begin n_fail++; $display("FAIL stall_err got %b want 0", bus_err); end
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] model [8];
      logic [31:0] rd, exp, wd; logic [3:0] ws; int lat, idx; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      for (int i = 0; i < 8; i++) begin
         model[i] = $urandom;
         cpu_req(32'h0000_0100 + 32'(4*i), model[i], 4'hF, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      end
      for (int n = 0; n < 24; n++) begin
         idx = $urandom_range(0, 7);
         ws  = (n % 3 == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         wd  = $urandom;
         exp_q.push_back(model[idx]);
         for (int b = 0; b < 4; b++) if (ws[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
         cpu_req(32'h0000_0100 + 32'(4*idx), wd, ws, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
         exp = exp_q.pop_front();
         n_cmp++;
         if (!got || rd !== exp || lat != 3 || !pok) begin
            n_fail++;
            $display("FAIL b2b_%0d got %h lat %0d want %h lat 3", n, rd, lat, exp);
         end
      end
   endtask

   task automatic test_reset_mid_flash();
      logic [31:0] rd, exp; int lat; logic got, pok, ss; logic [3:0] si; logic [23:0] sa;
      mem_addr = 32'h0100_0080; mem_wstrb = 4'h0; mem_valid = 1'b1; spimem_ready = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      n_cmp++;
      if (spimem_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid got %b want 1", spimem_valid); end
      #2 resetn = 1'b0;
      #1;
      n_cmp++;
      if (spimem_valid !== 1'b0 || mem_ready !== 1'b0) begin
         n_fail++; $display("FAIL midrst_async_drop got valid=%b ready=%b want 0/0", spimem_valid, mem_ready);
      end
      mem_valid = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (mem_ready !== 1'b0 || spimem_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_after got ready=%b valid=%b want 0/0", mem_ready, spimem_valid);
      end
      exp_q.push_back(32'h1234_AA78);
      cpu_req(32'h0000_0010, 32'd0, 4'h0, 0, 32'd0, rd, lat, got, pok, ss, si, sa);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!got || rd !== exp || lat != 3) begin n_fail++; $display("FAIL midrst_ram_read got %h lat %0d want %h lat 3", rd, lat, exp); end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
      spimem_ready = 1'b0; spimem_rdata = 32'd0; iomem_ready = 4'd0; iomem_rdata = '0; bus_err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      resetn = 1'b1;
      @(posedge clk); #1;
      test_ram();
      test_flash();
      test_io();
      test_unmapped();
`ifdef PICOSOC_MEMBUS_TIMEOUT_EN
      test_timeout();
`else
      test_long_stall();
`endif
      test_back_to_back();
      test_reset_mid_flash();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/picosoc_membus.md
Name: picosoc_membus

Overview:
- Parametrised successor to the SoC memory-bus glue. It routes the picorv32 native memory interface to four kinds of target: an internal byte-writable SRAM, the SPI flash controller port, NUM_IO independent iomem channels, and an unmapped-error responder.
- Each transaction is decoded once into a registered select, so target valids are glitch-free.
- Adds an optional stalled-target timeout, which completes the stalled transaction with an error.

Parameters:
MEM_WORDS, 256, internal SRAM depth in 32-bit words; power of two, at least 2.
NUM_IO, 4, number of iomem channels (1..16); channel k is decoded at mem_addr[31:24] == 8'h02+k.
TIMEOUT_CYCLES, 255, number of ACCESS cycles allowed before a forced error completion (2..65535).
ERR_RDATA, 32'hFFFF_FFFF, rdata returned on unmapped or timed-out reads.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
mem_valid  in  1  CPU request valid
mem_ready  out  1  CPU response, one-cycle pulse
mem_addr  in  32  CPU address
mem_wdata  in  32  CPU write data
mem_wstrb  in  4  byte strobes; 0 means read
mem_rdata  out  32  CPU read data
spimem_valid  out  1  flash request
spimem_ready  in  1  flash done
spimem_addr  out  24  mem_addr[23:0]
spimem_rdata  in  32  flash read data
iomem_valid  out  NUM_IO  one-hot channel request
iomem_ready  in  NUM_IO  per-channel done
iomem_wstrb  out  4  passthrough of mem_wstrb
iomem_addr  out  32  passthrough of mem_addr
iomem_wdata  out  32  passthrough of mem_wdata
iomem_rdata  in  32*NUM_IO  packed channel read data; channel k occupies bits [32k+31:32k]
bus_err  out  1  sticky flag: unmapped access or timeout
bus_err_addr  out  32  address of the first error since the last clear
bus_err_clr  in  1  synchronous clear of bus_err

Behaviour:
- Reset (async, resetn low): state IDLE; mem_ready 0; mem_rdata 0; spimem_valid 0; iomem_valid all 0; bus_err 0; bus_err_addr 0; timeout counter 0. SRAM contents are not reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: when mem_valid is high, decode mem_addr[31:24] and register sel, then go to ACCESS.
  - 0x00 selects RAM.
  - 0x01 selects FLASH.
  - 0x02..0x02+NUM_IO-1 selects IO[k].
  - Any other value selects UNMAPPED.
- ACCESS:
  - Drive the valid of the selected target only: spimem_valid = (sel==FLASH); iomem_valid[k] = (sel==IO[k]).
  - RAM completes in its first ACCESS cycle: read word mem_addr[log2(MEM_WORDS)+1:2], write the bytes enabled in mem_wstrb. The read returns pre-write data.
  - UNMAPPED completes in its first ACCESS cycle with ERR_RDATA.
  - FLASH or IO completes on the cycle its ready is high; the target's rdata is captured.
  - On completion: register mem_rdata, set mem_ready=1, go to RESP, drop the target valid.
- RESP: mem_ready stays high for exactly this one cycle, then IDLE.
- Latency from mem_valid to mem_ready:
  - RAM: 3 cycles (mem_ready high in the 3rd clock after mem_valid rises).
  - FLASH/IO: 2 cycles plus the target wait.
- Back-to-back requests: the CPU drops mem_valid after seeing ready. IDLE ignores mem_valid in the cycle immediately after RESP only if mem_valid is low; a new request is accepted on the next high sample.
- Target ready while not selected or outside ACCESS is ignored.
- Unmapped access: bus_err is set. bus_err_addr is loaded only if bus_err was 0.
- bus_err_clr: clears bus_err. If bus_err_clr and a new error occur in the same cycle, the set wins.
- Reset mid-transaction: abandons it immediately. No mem_ready is issued, all valids drop asynchronously.

Optional Feature:
PICOSOC_MEMBUS_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle.
  - When it reaches TIMEOUT_CYCLES-1 without a target ready, the transaction completes: ERR_RDATA is returned, the target valid drops, and bus_err/bus_err_addr update as for unmapped.
  - If ready arrives in the expiry cycle, the ready wins and no error is flagged.
- Undefined: no counter is built; a stalled target hangs the bus indefinitely.

Decomposition:
- Package picosoc_membus_pkg holds:
  - state enum: IDLE, ACCESS, RESP.
  - sel encoding: RAM, FLASH, IO base, UNMAPPED.
  - region constants: 8'h00, 8'h01, 8'h02.
  - default ERR_RDATA.
- One natural sub-module, picosoc_sram_bw: a single-port byte-write SRAM (MEM_WORDS, registered read).

Test Plan:
- RAM write 0x1234_5678 to 0x0000_0010 (wstrb=4'hF), then a write with wstrb=4'b0010 and data 0xAAAA_AAAA. Read back → 0x1234_AA78; mem_ready high in the 3rd cycle after mem_valid.
- Read of 0x0100_0040 with spimem_ready asserted 5 cycles after spimem_valid and spimem_rdata=0xCAFE_F00D → spimem_addr=0x00_0040; mem_rdata=0xCAFE_F00D; iomem_valid stays 0.
- Access to 0x0300_0000 with NUM_IO=4 → only iomem_valid[1] high. Drive ready and rdata 0x0000_0042 → mem_rdata=0x42.
- Read of 0x2000_0000 → mem_rdata=0xFFFF_FFFF, bus_err=1, bus_err_addr=0x2000_0000. A second error at 0x3000_0000 leaves bus_err_addr unchanged. Pulse bus_err_clr → bus_err=0.
- With TIMEOUT_EN and TIMEOUT_CYCLES=8, IO[0] ready never asserted → mem_ready after 8 ACCESS cycles, bus_err=1. Repeat with ready in the 8th cycle → normal data, bus_err stays 0.
- Assert resetn=0 mid-FLASH wait → spimem_valid and mem_ready fall immediately. After release, state is IDLE and a RAM read completes normally.
